// File: rtl/wb_stage_regfile_pkg.sv
// Shared widths, the zero-register constant and the last-commit record
// used by MEM/WB, write-back and the EX forwarding unit.
package wb_stage_regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } last_wr_t;

    // r0 first, then same-cycle bypass, then the array value.
    function automatic logic [DATA_W-1:0] port_sel(
        input logic [ADDR_W-1:0] addr,
        input logic              commit,
        input logic [ADDR_W-1:0] rd,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] arr_val
    );
        if (addr == REG_ZERO)
            return '0;
        if (commit && (addr == rd))
            return wb_val;
        return arr_val;
    endfunction

endpackage

// File: rtl/wb_stage_regfile_if.sv
// MEM/WB register outputs as seen by the write-back stage.
interface wb_stage_regfile_if;
    import wb_stage_regfile_pkg::*;

    logic              mem_to_reg_in;
    logic              reg_write_in;
    logic [ADDR_W-1:0] rd_in;
    logic [DATA_W-1:0] read_data_in;
    logic [DATA_W-1:0] alu_res_in;

    modport master (
        output mem_to_reg_in,
        output reg_write_in,
        output rd_in,
        output read_data_in,
        output alu_res_in
    );

    modport slave (
        input mem_to_reg_in,
        input reg_write_in,
        input rd_in,
        input read_data_in,
        input alu_res_in
    );

endinterface

// File: rtl/wb_stage_regfile_regfile.sv
// Architectural register array: two async read ports, one write port.
// No bypass here; the write-back stage layers it on top.
module regfile_2r1w
    import wb_stage_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we)
            regs_d[waddr] = wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata_a = regs_q[raddr_a];
        rdata_b = regs_q[raddr_b];
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage: result mux, commit qualifier, bypassed ID reads,
// last-commit record for forwarding and a retire counter.
module wb_stage_regfile
    import wb_stage_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    wb_stage_regfile_if.slave memwb,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              last_we,
    output logic [ADDR_W-1:0] last_rd,
    output logic [DATA_W-1:0] last_data,
    output logic [31:0]       retire_count
);

    logic              commit;
    logic [DATA_W-1:0] arr_a;
    logic [DATA_W-1:0] arr_b;
    last_wr_t          last_d;
    last_wr_t          last_q;
    logic [31:0]       retire_count_d;
    logic [31:0]       retire_count_q;

    // Reset gates commit so neither the array nor the bypass sees a write.
    always_comb begin
        wb_data = memwb.mem_to_reg_in ? memwb.read_data_in
                                      : memwb.alu_res_in;
        commit  = memwb.reg_write_in
                  && (memwb.rd_in != REG_ZERO)
                  && reset;
    end

    regfile_2r1w u_rf (
        .clk     (clk),
        .rst_n   (reset),
        .we      (commit),
        .waddr   (memwb.rd_in),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (arr_a),
        .rdata_b (arr_b)
    );

    always_comb begin
        rs_data = port_sel(rs_addr, commit, memwb.rd_in, wb_data, arr_a);
        rt_data = port_sel(rt_addr, commit, memwb.rd_in, wb_data, arr_b);
    end

    always_comb begin
        last_d         = last_q;
        last_d.we      = 1'b0;
        retire_count_d = retire_count_q;
        if (commit) begin
            last_d.we      = 1'b1;
            last_d.rd      = memwb.rd_in;
            last_d.data    = wb_data;
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q         <= '0;
            retire_count_q <= '0;
        end else begin
            last_q         <= last_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_comb begin
        last_we      = last_q.we;
        last_rd      = last_q.rd;
        last_data    = last_q.data;
        retire_count = retire_count_q;
    end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Randomised bench for wb_stage_regfile against an array-based
// model of the architectural register state.
module tb_wb_stage_regfile;
    import wb_stage_regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic        last_we;
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mregs [32];
    logic [31:0] mcount;
    logic        mlast_we;
    logic [4:0]  mlast_rd;
    logic [31:0] mlast_data;

    wb_stage_regfile_if memwb ();

    wb_stage_regfile dut (
        .clk          (clk),
        .reset        (rst_n),
        .memwb        (memwb.slave),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .wb_data      (wb_data),
        .last_we      (last_we),
        .last_rd      (last_rd),
        .last_data    (last_data),
        .retire_count (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst_n)
            assert (!$isunknown(memwb.reg_write_in))
                else $error("FAIL proto reg_write_in is X/Z");

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] m_wb();
        return memwb.mem_to_reg_in ? memwb.read_data_in
                                   : memwb.alu_res_in;
    endfunction

    function automatic bit m_commit();
        return (memwb.reg_write_in === 1'b1)
               && (memwb.rd_in != 5'd0) && (rst_n === 1'b1);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
        if (m_commit() && a == memwb.rd_in)
            return m_wb();
        return mregs[a];
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++)
            mregs[i] = 32'd0;
        mcount     = 32'd0;
        mlast_we   = 1'b0;
        mlast_rd   = 5'd0;
        mlast_data = 32'd0;
    endtask

    // Advance one clock from negedge to negedge, updating the model.
    task automatic step();
        bit          c;
        logic [4:0]  rd;
        logic [31:0] v;
        c  = m_commit();
        rd = memwb.rd_in;
        v  = m_wb();
        @(posedge clk);
        if (c) begin
            mregs[rd]  = v;
            mcount     = mcount + 32'd1;
            mlast_we   = 1'b1;
            mlast_rd   = rd;
            mlast_data = v;
        end else begin
            mlast_we = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic m2r,
                         input logic [4:0] rd,
                         input logic [31:0] rdat,
                         input logic [31:0] alu);
        memwb.reg_write_in  = we;
        memwb.mem_to_reg_in = m2r;
        memwb.rd_in         = rd;
        memwb.read_data_in  = rdat;
        memwb.alu_res_in    = alu;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        rst_n   = 1'b0;
        m_clear();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            checks++;
            if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_read a=%0d rs=%h rt=%h want 0",
                         i, rs_data, rt_data);
            end
        end
        checks++;
        if (retire_count !== 32'd0 || last_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_state cnt=%h we=%b want 0/0",
                     retire_count, last_we);
        end
        @(negedge clk);
    endtask

    task automatic test_bypass();
        drive(1'b1, 1'b0, 5'd5, 32'h0, 32'hDEAD_BEEF);
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'd0) begin
            errors++;
            $display("FAIL bypass rs=%h rt=%h want deadbeef/0",
                     rs_data, rt_data);
        end
        step();
        memwb.reg_write_in = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'hDEAD_BEEF || last_we !== 1'b1
            || last_rd !== 5'd5 || last_data !== 32'hDEAD_BEEF
            || retire_count !== 32'd1) begin
            errors++;
            $display("FAIL commit rs=%h we=%b rd=%0d d=%h cnt=%0d want deadbeef/1/5/deadbeef/1",
                     rs_data, last_we, last_rd, last_data, retire_count);
        end
    endtask

    task automatic test_r0();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 32'h1234);
        rs_addr = 5'd0;
        #1;
        checks++;
        if (rs_data !== 32'd0 || wb_data !== 32'h1234) begin
            errors++;
            $display("FAIL r0_read rs=%h wb=%h want 0/1234",
                     rs_data, wb_data);
        end
        step();
        memwb.reg_write_in = 1'b0;
        #1;
        checks++;
        if (retire_count !== 32'd1 || last_we !== 1'b0
            || last_rd !== 5'd5) begin
            errors++;
            $display("FAIL r0_drop cnt=%0d we=%b rd=%0d want 1/0/5",
                     retire_count, last_we, last_rd);
        end
    endtask

    task automatic test_mem_to_reg();
        drive(1'b1, 1'b1, 5'd7, 32'hCAFE_0001, 32'h0);
        rs_addr = 5'd7;
        rt_addr = 5'd7;
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_0001 || rt_data !== 32'hCAFE_0001
            || wb_data !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL m2r_bypass rs=%h rt=%h wb=%h want cafe0001",
                     rs_data, rt_data, wb_data);
        end
        step();
        memwb.reg_write_in = 1'b0;
        #1;
        checks++;
        if (rs_data !== 32'hCAFE_0001 || rt_data !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL m2r_array rs=%h rt=%h want cafe0001",
                     rs_data, rt_data);
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 5'd9, 32'h0, 32'hAAAA);
        step();
        drive(1'b1, 1'b0, 5'd9, 32'h0, 32'hBBBB);
        rs_addr = 5'd9;
        rt_addr = 5'd7;
        #1;
        checks++;
        if (rs_data !== 32'hBBBB) begin
            errors++;
            $display("FAIL pre_rst_bypass rs=%h want bbbb", rs_data);
        end
        rst_n = 1'b0;
        m_clear();
        #1;
        checks++;
        if (rs_data !== 32'd0 || rt_data !== 32'd0
            || retire_count !== 32'd0 || last_we !== 1'b0
            || last_rd !== 5'd0 || last_data !== 32'd0
            || wb_data !== 32'hBBBB) begin
            errors++;
            $display("FAIL async_rst rs=%h rt=%h cnt=%0d we=%b rd=%0d d=%h wb=%h want 0s wb=bbbb",
                     rs_data, rt_data, retire_count, last_we,
                     last_rd, last_data, wb_data);
        end
        @(posedge clk);
        @(negedge clk);
        memwb.reg_write_in = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (rs_data !== 32'd0 || retire_count !== 32'd0) begin
            errors++;
            $display("FAIL rst_no_write r9=%h cnt=%0d want 0/0",
                     rs_data, retire_count);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        v = $urandom;
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        mcount = 32'hFFFF_FFFF;
        drive(1'b1, 1'b0, 5'd3, 32'h0, v);
        rs_addr = 5'd1;
        #1;
        checks++;
        if (retire_count !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preset cnt=%h want ffffffff",
                     retire_count);
        end
        step();
        memwb.reg_write_in = 1'b0;
        rs_addr = 5'd3;
        #1;
        checks++;
        if (retire_count !== 32'd0 || rs_data !== v) begin
            errors++;
            $display("FAIL wrap cnt=%h r3=%h want 0/%h",
                     retire_count, rs_data, v);
        end
    endtask

    task automatic test_random();
        logic [4:0] rd;
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0)
                rd = 5'd0;
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom),
                  rd, $urandom, $urandom);
            rs_addr = ($urandom_range(0, 2) == 0) ? rd
                                                   : 5'($urandom);
            rt_addr = ($urandom_range(0, 2) == 0) ? rd
                                                   : 5'($urandom);
            #1;
            checks++;
            if (rs_data !== m_read(rs_addr) || rt_data !== m_read(rt_addr)
                || wb_data !== m_wb()) begin
                errors++;
                $display("FAIL rnd_read n=%0d rs=%h/%h rt=%h/%h wb=%h/%h",
                         n, rs_data, m_read(rs_addr), rt_data,
                         m_read(rt_addr), wb_data, m_wb());
            end
            step();
            #1;
            checks++;
            if (last_we !== mlast_we || last_rd !== mlast_rd
                || last_data !== mlast_data || retire_count !== mcount) begin
                errors++;
                $display("FAIL rnd_last n=%0d we=%b/%b rd=%0d/%0d d=%h/%h cnt=%0d/%0d",
                         n, last_we, mlast_we, last_rd, mlast_rd,
                         last_data, mlast_data, retire_count, mcount);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        @(negedge clk);
        test_reset();
        test_bypass();
        test_r0();
        test_mem_to_reg();
        test_async_reset();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
